// File: rtl/invaders_pkg.sv
// invaders_pkg: geometry, sprite art, FSM states and colours shared
// by the invader formation and the later player/bunker renderers.
package invaders_pkg;

  localparam int CELL_SHIFT  = 6;
  localparam int SCALE_SHIFT = 2;
  localparam int CELL_PX     = 1 << CELL_SHIFT;

  // Indexed [row][col]; col 0 is the leftmost sprite pixel.
  localparam logic [0:7][0:7] ANIM0 = {
    8'b10000001,
    8'b01011010,
    8'b11111111,
    8'b11011011,
    8'b11111111,
    8'b00100100,
    8'b01011010,
    8'b10100101
  };

  localparam logic [0:7][0:7] ANIM1 = {
    8'b10100101,
    8'b10011001,
    8'b11111111,
    8'b11011011,
    8'b11111111,
    8'b00100100,
    8'b01000010,
    8'b00100100
  };

  typedef enum logic {
    MARCH = 1'b0,
    HALT  = 1'b1
  } state_e;

  localparam logic [23:0] COL_WHITE = 24'hFF_FF_FF;
  localparam logic [23:0] COL_BLACK = 24'h00_00_00;

endpackage

// File: rtl/invader_sprite_rom.sv
// invader_sprite_rom: combinational 8x8 sprite lookup.
// anim_i picks the frame, row_i/col_i pick the pixel, bit_o = lit.
module invader_sprite_rom
  import invaders_pkg::*;
(
  input  logic       anim_i,
  input  logic [2:0] row_i,
  input  logic [2:0] col_i,
  output logic       bit_o
);

  always_comb begin
    if (anim_i) bit_o = ANIM1[row_i][col_i];
    else        bit_o = ANIM0[row_i][col_i];
  end

endmodule

// File: rtl/invader_field.sv
// invader_field: renders the marching formation to 24-bit RGB,
// 2-cycle pixel latency. In: clock, resetn, X, Y, display, kill_*.
// Out: kill_ready, R/G/B, display_out, frame_end, landed, cleared.
module invader_field
  import invaders_pkg::*;
#(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 1024,
  parameter int ROWS        = 5,
  parameter int COLS        = 11,
  parameter int STEP_FRAMES = 30,
  parameter int STEP_PX     = 8,
  parameter int DROP_PX     = 32,
  parameter int START_X     = 64,
  parameter int START_Y     = 64,
  parameter int LAND_Y      = 896
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic        display,
  input  logic        kill_valid,
  input  logic [2:0]  kill_row,
  input  logic [3:0]  kill_col,
  output logic        kill_ready,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        display_out,
  output logic        frame_end,
  output logic        landed,
  output logic        cleared
);

  localparam logic [31:0] FORM_W = 32'(COLS * CELL_PX);
  localparam logic [31:0] FORM_H = 32'(ROWS * CELL_PX);
  localparam logic [31:0] STEP   = 32'(STEP_PX);
  localparam logic [31:0] DROP   = 32'(DROP_PX);
  localparam logic [31:0] HMAX   = 32'(H_ACTIVE);
  localparam logic [31:0] LAND   = 32'(LAND_Y);
  localparam logic [31:0] YLAST  = 32'(V_ACTIVE - 1);
  localparam logic [15:0] FLAST  = 16'(STEP_FRAMES - 1);

  // Lanes outside ROWS x COLS stay zero forever, so kills aimed
  // there clear an already-clear bit and fall through harmlessly.
  function automatic logic [7:0][15:0] alive_init();
    logic [7:0][15:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m[r][c] = 1'b1;
    return m;
  endfunction

  localparam logic [7:0][15:0] ALIVE_INIT = alive_init();

  state_e           state_q, state_d;
  logic [31:0]      org_x_q, org_x_d;
  logic [31:0]      org_y_q, org_y_d;
  logic             left_q, left_d;
  logic             anim_q, anim_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic [7:0][15:0] alive_q, alive_d;
  logic             landed_q, landed_d;
  logic             cleared_q, cleared_d;
  logic             rdy_q;
  logic             drop;
  logic             disp_prev_q;
  logic             frame_end_q;
  logic [31:0]      rel_x, rel_y;
  logic [7:0]       rx_q;
  logic [6:0]       ry_q;
  logic             in1_q, disp1_q, disp2_q;
  logic             spr_bit, lit;
  logic [23:0]      rgb_q;

  assign kill_ready = rdy_q && (state_q == MARCH);

  always_comb begin
    state_d   = state_q;
    org_x_d   = org_x_q;
    org_y_d   = org_y_q;
    left_d    = left_q;
    anim_d    = anim_q;
    fcnt_d    = fcnt_q;
    alive_d   = alive_q;
    landed_d  = landed_q;
    cleared_d = cleared_q;
    drop      = 1'b0;
    if (kill_valid && kill_ready)
      alive_d[kill_row][kill_col] = 1'b0;
    unique case (state_q)
      MARCH: begin
        if (frame_end_q) begin
          if (fcnt_q == FLAST) begin
            fcnt_d = '0;
            anim_d = ~anim_q;
            if (left_q) drop = org_x_q < STEP;
            else        drop = org_x_q + FORM_W + STEP > HMAX;
            if (drop) begin
              org_y_d = org_y_q + DROP;
              left_d  = ~left_q;
              if (org_y_d + FORM_H >= LAND) begin
                state_d  = HALT;
                landed_d = 1'b1;
              end
            end else if (left_q) begin
              org_x_d = org_x_q - STEP;
            end else begin
              org_x_d = org_x_q + STEP;
            end
          end else begin
            fcnt_d = fcnt_q + 16'd1;
          end
        end
        // Looking at the next bitmap makes cleared land one
        // cycle after the final kill.
        if (alive_d == '0) begin
          state_d   = HALT;
          cleared_d = 1'b1;
        end
      end
      HALT: begin
      end
    endcase
  end

  assign rel_x = X - org_x_q;
  assign rel_y = Y - org_y_q;

  invader_sprite_rom u_rom (
    .anim_i (anim_q),
    .row_i  (ry_q[2:0]),
    .col_i  (rx_q[2:0]),
    .bit_o  (spr_bit)
  );

  // rx_q = rel_x[9:2]: [7:4] cell col, [3] right half, [2:0] sprite col.
  assign lit = disp1_q && in1_q && !rx_q[3] && !ry_q[3]
            && spr_bit && alive_q[ry_q[6:4]][rx_q[7:4]];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= MARCH;
      org_x_q     <= 32'(START_X);
      org_y_q     <= 32'(START_Y);
      left_q      <= 1'b0;
      anim_q      <= 1'b0;
      fcnt_q      <= '0;
      alive_q     <= ALIVE_INIT;
      landed_q    <= 1'b0;
      cleared_q   <= 1'b0;
      rdy_q       <= 1'b0;
      disp_prev_q <= 1'b0;
      frame_end_q <= 1'b0;
      rx_q        <= '0;
      ry_q        <= '0;
      in1_q       <= 1'b0;
      disp1_q     <= 1'b0;
      disp2_q     <= 1'b0;
      rgb_q       <= COL_BLACK;
    end else begin
      state_q     <= state_d;
      org_x_q     <= org_x_d;
      org_y_q     <= org_y_d;
      left_q      <= left_d;
      anim_q      <= anim_d;
      fcnt_q      <= fcnt_d;
      alive_q     <= alive_d;
      landed_q    <= landed_d;
      cleared_q   <= cleared_d;
      rdy_q       <= 1'b1;
      disp_prev_q <= display;
      frame_end_q <= disp_prev_q && !display && (Y == YLAST);
      rx_q        <= rel_x[CELL_SHIFT+3:SCALE_SHIFT];
      ry_q        <= rel_y[CELL_SHIFT+2:SCALE_SHIFT];
      in1_q       <= (rel_x < FORM_W) && (rel_y < FORM_H);
      disp1_q     <= display;
      disp2_q     <= disp1_q;
      rgb_q       <= lit ? COL_WHITE : COL_BLACK;
    end
  end

  assign R           = rgb_q[23:16];
  assign G           = rgb_q[15:8];
  assign B           = rgb_q[7:0];
  assign display_out = disp2_q;
  assign frame_end   = frame_end_q;
  assign landed      = landed_q;
  assign cleared     = cleared_q;

endmodule

// File: tb/tb_invader_field.sv
// tb_invader_field: sparse-frame stimulus against a geometric pixel
// model of the formation, plus hand-computed literal pixel pins.
module tb_invader_field;

  localparam int HA   = 1280;
  localparam int VA   = 1024;
  localparam int ROWS = 5;
  localparam int COLS = 11;
  localparam int SF   = 1;
  localparam int STEP = 8;
  localparam int DROP = 32;
  localparam int SX   = 64;
  localparam int SY   = 64;
  localparam int LAND = 448;
  localparam logic [23:0] WH = 24'hFFFFFF;
  localparam logic [23:0] BK = 24'h000000;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] X = '0;
  logic [31:0] Y = '0;
  logic        display = 1'b0;
  logic        kill_valid = 1'b0;
  logic [2:0]  kill_row = '0;
  logic [3:0]  kill_col = '0;
  logic        kill_ready;
  logic [7:0]  R, G, B;
  logic        display_out, frame_end, landed, cleared;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  invader_field #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .ROWS(ROWS), .COLS(COLS),
    .STEP_FRAMES(SF), .STEP_PX(STEP), .DROP_PX(DROP),
    .START_X(SX), .START_Y(SY), .LAND_Y(LAND)
  ) dut (
    .clock(clock), .resetn(resetn), .X(X), .Y(Y),
    .display(display), .kill_valid(kill_valid),
    .kill_row(kill_row), .kill_col(kill_col),
    .kill_ready(kill_ready), .R(R), .G(G), .B(B),
    .display_out(display_out), .frame_end(frame_end),
    .landed(landed), .cleared(cleared)
  );

  logic [7:0] a0 [8] = '{8'b10000001, 8'b01011010, 8'b11111111,
    8'b11011011, 8'b11111111, 8'b00100100, 8'b01011010, 8'b10100101};
  logic [7:0] a1 [8] = '{8'b10100101, 8'b10011001, 8'b11111111,
    8'b11011011, 8'b11111111, 8'b00100100, 8'b01000010, 8'b00100100};

  int m_ox, m_oy, m_fcnt;
  bit m_left, m_anim, m_halt, m_landed, m_cleared, m_started;
  bit m_prev, e_fe, e_d0, e_d1;
  bit m_alive [8][16];
  logic [23:0] e_rgb0, e_rgb1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] colour(input int x, input int y,
                                         input bit d);
    int dx, dy;
    logic [7:0] rb;
    dx = x - m_ox;
    dy = y - m_oy;
    if (!d || dx < 0 || dy < 0) return BK;
    if (dx >= 64 * COLS || dy >= 64 * ROWS) return BK;
    if (dx % 64 >= 32 || dy % 64 >= 32) return BK;
    rb = m_anim ? a1[(dy % 64) / 4] : a0[(dy % 64) / 4];
    if (m_alive[dy / 64][dx / 64] && rb[7 - (dx % 64) / 4]) return WH;
    return BK;
  endfunction

  task automatic model_reset();
    m_ox = SX; m_oy = SY; m_fcnt = 0;
    m_left = 0; m_anim = 0; m_halt = 0;
    m_landed = 0; m_cleared = 0; m_started = 0;
    m_prev = 0; e_fe = 0; e_d0 = 0; e_d1 = 0;
    e_rgb0 = BK; e_rgb1 = BK;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++)
        m_alive[r][c] = (r < ROWS) && (c < COLS);
  endtask

  always @(negedge clock) begin
    bit fe_cur, kr_cur, halt_cur, dead;
    if (!resetn) begin
      model_reset();
      chk("rst_rgb", {R, G, B}, 0);
      chk("rst_disp_out", display_out, 0);
      chk("rst_frame_end", frame_end, 0);
      chk("rst_landed", landed, 0);
      chk("rst_cleared", cleared, 0);
      chk("rst_kill_ready", kill_ready, 0);
    end else begin
      kr_cur = m_started && !m_halt;
      chk("rgb", {R, G, B}, e_rgb1);
      chk("display_out", display_out, e_d1);
      chk("frame_end", frame_end, e_fe);
      chk("landed", landed, m_landed);
      chk("cleared", cleared, m_cleared);
      chk("kill_ready", kill_ready, kr_cur);
      m_started = 1;
      e_rgb1 = e_rgb0;
      e_rgb0 = colour(int'(X), int'(Y), display);
      e_d1 = e_d0;
      e_d0 = display;
      fe_cur = e_fe;
      e_fe = m_prev && !display && (Y == VA - 1);
      m_prev = display;
      halt_cur = m_halt;
      if (fe_cur && !halt_cur) begin
        if (m_fcnt == SF - 1) begin
          m_fcnt = 0;
          m_anim = !m_anim;
          if ((!m_left && m_ox + 64 * COLS + STEP > HA) ||
              (m_left && m_ox < STEP)) begin
            m_oy += DROP;
            m_left = !m_left;
            if (m_oy + 64 * ROWS >= LAND) begin
              m_halt = 1;
              m_landed = 1;
            end
          end else begin
            m_ox += m_left ? -STEP : STEP;
          end
        end else begin
          m_fcnt++;
        end
      end
      if (kill_valid && kr_cur && kill_row < ROWS && kill_col < COLS)
        m_alive[kill_row][kill_col] = 0;
      dead = 1;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (m_alive[r][c]) dead = 0;
      if (!halt_cur && dead) begin
        m_halt = 1;
        m_cleared = 1;
      end
    end
  end

  task automatic cyc(input int x, input int y, input bit d);
    @(posedge clock); #1;
    X = 32'(x); Y = 32'(y); display = d; kill_valid = 0;
  endtask

  task automatic kill(input int r, input int c);
    @(posedge clock); #1;
    X = 0; Y = VA - 1; display = 0;
    kill_valid = 1; kill_row = 3'(r); kill_col = 4'(c);
  endtask

  task automatic lit(input string name, input int x, input int y,
                     input logic [23:0] exp);
    cyc(x, y, 1);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk(name, {R, G, B}, exp);
  endtask

  task automatic release_rst();
    @(posedge clock); #1;
    resetn = 1; X = 0; Y = VA - 1; display = 0; kill_valid = 0;
  endtask

  task automatic frame(input int kr, input int kc);
    for (int dy = 0; dy <= 8; dy += 8)
      for (int dx = 0; dx < 36; dx += 4)
        cyc(m_ox + dx, m_oy + dy, 1);
    if (m_ox > 0) cyc(m_ox - 1, m_oy, 1);
    for (int dx = 0; dx < 40; dx += 4)
      cyc(m_ox + 640 + dx, m_oy + 256, 1);
    cyc(m_ox + 704, m_oy, 1);
    for (int k = 0; k < 4; k++)
      cyc($urandom_range(0, HA - 1), $urandom_range(0, VA - 1), 1);
    cyc(HA - 1, VA - 1, 1);
    cyc(0, VA - 1, 0);
    if (kr >= 0) kill(kr, kc);
    else cyc(0, VA - 1, 0);
    repeat (3) cyc(0, VA - 1, 0);
  endtask

  initial begin
    repeat (3) cyc(0, 0, 0);
    release_rst();
    @(negedge clock);
    chk("kready_at_release", kill_ready, 0);
    @(negedge clock);
    chk("kready_after", kill_ready, 1);
    kill(2, 3);
    @(negedge clock);
    chk("kready_during_kill", kill_ready, 1);
    kill(7, 15);
    cyc(0, VA - 1, 0);
    cyc(0, VA - 1, 0);
    cyc(64, 64, 1);
    @(posedge clock);
    @(negedge clock);
    chk("lat_t1_rgb", {R, G, B}, BK);
    chk("lat_t1_disp", display_out, 0);
    @(posedge clock);
    @(negedge clock);
    chk("lat_t2_rgb", {R, G, B}, WH);
    chk("lat_t2_disp", display_out, 1);
    lit("black_63_64", 63, 64, BK);
    lit("black_768_64", 768, 64, BK);
    lit("killed_2_3", 256, 192, BK);
    lit("alive_2_4", 320, 192, WH);
    for (int y = 192; y < 224; y++)
      for (int x = 256; x < 288; x++)
        cyc(x, y, 1);
    chk("kready_kept", kill_ready, 1);
    frame(-1, 0);
    for (int f = 1; f <= 140; f++) begin
      if (f == 64) begin
        lit("edge_576", 576, 64, WH);
        lit("edge_575", 575, 64, BK);
      end
      if (f == 65) begin
        lit("drop_576_96", 576, 96, WH);
        lit("drop_576_64", 576, 64, BK);
      end
      if (f == 66) begin
        lit("rev_568", 568, 96, WH);
        lit("rev_567", 567, 96, BK);
      end
      if (f == 138) begin
        chk("landed_set", landed, 1);
        chk("landed_kready", kill_ready, 0);
        lit("land_0_128", 0, 128, WH);
        lit("land_0_96", 0, 96, BK);
      end
      if (f == 140) lit("frozen_0_128", 0, 128, WH);
      frame(f == 10 ? 0 : -1, 10);
    end
    repeat (3) cyc(0, 128, 1);
    @(posedge clock); #1;
    resetn = 0;
    @(negedge clock);
    chk("midrst_rgb", {R, G, B}, BK);
    chk("midrst_disp", display_out, 0);
    chk("midrst_landed", landed, 0);
    chk("midrst_kready", kill_ready, 0);
    cyc(0, VA - 1, 1);
    cyc(0, VA - 1, 1);
    release_rst();
    cyc(0, VA - 1, 0);
    cyc(0, VA - 1, 0);
    @(negedge clock);
    chk("no_fe_after_rst", frame_end, 0);
    lit("restored_2_3", 256, 192, WH);
    lit("restored_0_10", 704, 64, WH);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        kill(r, c);
    @(negedge clock);
    chk("last_kill_cleared", cleared, 0);
    cyc(0, VA - 1, 0);
    @(negedge clock);
    chk("cleared_set", cleared, 1);
    chk("cleared_kready", kill_ready, 0);
    frame(-1, 0);
    frame(-1, 0);
    lit("dead_64_64", 64, 64, BK);
    chk("cleared_sticky", cleared, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
